// File: rtl/mul_booth_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_booth_seq_if
//  Description : EX-stage handshake between the pipeline and the iterative
//                multiplier (operands, valid/sign, flush, stall, product).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_booth_seq_if;
    logic        flush;
    logic        valid;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        mul_stall;
    logic [63:0] result;

    modport master (
        output flush, valid, sign, a, b,
        input  mul_stall, result
    );

    modport slave (
        input  flush, valid, sign, a, b,
        output mul_stall, result
    );
endinterface
`default_nettype wire

// File: rtl/mul_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_booth_seq
//  Description : Iterative 32x32 Booth multiplier for MULT/MULTU producing the
//                64-bit {HI,LO} product. Define MUL_RADIX4_EN for radix-4
//                (17 iterations); otherwise radix-2 (33 iterations).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_booth_seq (
    input  logic           clk,
    input  logic           resetn,
    mul_booth_seq_if.slave bus
);

`ifdef MUL_RADIX4_EN
    localparam int         W = 2;
    localparam int         K = 34;
    localparam logic [5:0] N = 6'd17;
`else
    localparam int         W = 1;
    localparam int         K = 33;
    localparam logic [5:0] N = 6'd33;
`endif
    // K = N*W low bits, so the final accumulator holds the exact product.
    localparam int UW = 36;
    localparam int AW = K + UW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic [5:0]    cnt_q,    cnt_d;
    logic [33:0]   m_q,      m_d;
    logic [34:0]   mr_q,     mr_d;
    logic [AW-1:0] acc_q,    acc_d;
    logic [63:0]   result_q, result_d;

    logic          dig_zero;
    logic          dig_neg;
    logic          dig_two;
    logic [UW-1:0] m_ext;
    logic [UW-1:0] base;
    logic [UW-1:0] addend;
    logic [UW-1:0] upper_sum;
    logic [AW-1:0] acc_sum;
    logic [AW-1:0] acc_shift;

    // Booth digit from the low multiplier bits; bit 0 of mr_q is b[i-1].
    always_comb begin
        dig_zero = 1'b1;
        dig_neg  = 1'b0;
        dig_two  = 1'b0;
`ifdef MUL_RADIX4_EN
        case (mr_q[2:0])
            3'b001, 3'b010: begin dig_zero = 1'b0; end
            3'b011:         begin dig_zero = 1'b0; dig_two = 1'b1; end
            3'b100:         begin dig_zero = 1'b0; dig_two = 1'b1; dig_neg = 1'b1; end
            3'b101, 3'b110: begin dig_zero = 1'b0; dig_neg = 1'b1; end
            default:        begin dig_zero = 1'b1; end
        endcase
`else
        dig_zero = (mr_q[1] == mr_q[0]);
        dig_neg  = mr_q[1];
`endif
    end

    always_comb begin
        m_ext     = {{(UW-34){m_q[33]}}, m_q};
        base      = dig_two ? (m_ext << 1) : m_ext;
        addend    = dig_zero ? '0 : (dig_neg ? (~base + {{(UW-1){1'b0}}, 1'b1}) : base);
        upper_sum = acc_q[AW-1:K] + addend;
        acc_sum   = {upper_sum, acc_q[K-1:0]};
        acc_shift = $signed(acc_sum) >>> W;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        mr_d     = mr_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.valid) begin
                        m_d     = bus.sign ? {{2{bus.a[31]}}, bus.a} : {2'b00, bus.a};
                        mr_d    = {(bus.sign ? {2{bus.b[31]}} : 2'b00), bus.b, 1'b0};
                        acc_d   = '0;
                        cnt_d   = 6'd1;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_d = acc_shift;
                    mr_d  = mr_q >> W;
                    if (cnt_q == N) begin
                        result_d = acc_shift[63:0];
                        cnt_d    = 6'd0;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            m_q      <= '0;
            mr_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            mr_q     <= mr_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Stall is forced low while reset is asserted, even if EX holds valid.
    assign bus.mul_stall = resetn &
                           (((state_q == S_IDLE) & bus.valid & ~bus.flush) |
                            (state_q == S_BUSY));
    assign bus.result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_booth_seq
//  Description : Directed self-checking bench for mul_booth_seq (either build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_booth_seq;

`ifdef MUL_RADIX4_EN
    localparam int N = 17;
`else
    localparam int N = 33;
`endif

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    mul_booth_seq_if bus ();

    mul_booth_seq dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one multiply from IDLE, counts stall cycles, checks the product in DONE.
    task automatic run_mul(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                           input logic [63:0] exp, input bit chg, input string tag);
        int n;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.sign  = ts;
        bus.valid = 1'b1;
        n = 0;
        #1;
        while (bus.mul_stall && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (chg && n == 1) begin
                bus.a = 32'hDEADBEEF;
                bus.b = 32'hDEADBEEF;
            end
        end
        bus.valid = 1'b0;
        check_val({tag, "_result"}, bus.result, exp);
        check_val({tag, "_stall_len"}, 64'(n), 64'(N + 1));
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int n2;
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        bus.flush  = 1'b0;
        bus.valid  = 1'b0;
        bus.sign   = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        #1;
        check_val("rst_stall", 64'(bus.mul_stall), 64'd0);
        check_val("rst_result", bus.result, 64'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 1'b0, "umax");
        check_val("umax_hold", bus.result, 64'hFFFFFFFE_00000001);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, 1'b0, "sneg1");
        run_mul(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 1'b0, "smin2");
        run_mul(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000, 1'b0, "smin1");
        run_mul(32'h00001234, 32'h00000010, 1'b0, 64'h00000000_00012340, 1'b1, "capture");

        // Flush five cycles after issue
        bus.a     = 32'h12345678;
        bus.b     = 32'h00000009;
        bus.sign  = 1'b0;
        bus.valid = 1'b1;
        #1;
        check_val("flush_issue_stall", 64'(bus.mul_stall), 64'd1);
        repeat (5) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        bus.valid = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check_val("flush_stall", 64'(bus.mul_stall), 64'd0);
        check_val("flush_result", bus.result, 64'h00000000_00012340);
        run_mul(32'h00000007, 32'h00000006, 1'b1, 64'h00000000_0000002A, 1'b0, "post_flush");

        // Asynchronous reset in the middle of BUSY, valid still held
        bus.a     = 32'h00000005;
        bus.b     = 32'h00000005;
        bus.sign  = 1'b1;
        bus.valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        check_val("midrst_stall", 64'(bus.mul_stall), 64'd0);
        check_val("midrst_result", bus.result, 64'h0);
        bus.valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_idle_stall", 64'(bus.mul_stall), 64'd0);

        // Back-to-back with valid held high
        bus.a     = 32'hFFFFFFFD;
        bus.b     = 32'h00000005;
        bus.sign  = 1'b1;
        bus.valid = 1'b1;
        n = 0;
        #1;
        while (bus.mul_stall && n < 200) begin @(posedge clk); #1; n++; end
        check_val("b2b1_result", bus.result, 64'hFFFFFFFF_FFFFFFF1);
        check_val("b2b1_stall_len", 64'(n), 64'(N + 1));
        bus.a = 32'h7FFFFFFF;
        bus.b = 32'h00000002;
        @(posedge clk); #1;
        check_val("b2b_gap", 64'(bus.mul_stall), 64'd1);
        n2 = 0;
        while (bus.mul_stall && n2 < 200) begin @(posedge clk); #1; n2++; end
        bus.valid = 1'b0;
        check_val("b2b2_result", bus.result, 64'h00000000_FFFFFFFE);
        check_val("b2b2_stall_len", 64'(n2), 64'(N + 1));
        @(posedge clk); #1;
        check_val("b2b2_hold", bus.result, 64'h00000000_FFFFFFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
